// File: rtl/cla_pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor built from GROUP-bit carry-lookahead slices,
// one slice per stage, with a registered inter-stage carry and valid/ready flow control.
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LAT = WIDTH / GROUP;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;

    // Returns {carry_out, sum}; every internal carry is a flat sum of products of g/p/ci.
    function automatic logic [GROUP:0] cla_slice(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             ci);
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             t;
        g = x & y;
        p = x ^ y;
        for (int i = 0; i <= GROUP; i++) begin
            c[i] = ci;
            for (int j = 0; j < i; j++) c[i] = c[i] & p[j];
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int m = j + 1; m < i; m++) t = t & p[m];
                c[i] = c[i] | t;
            end
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        localparam int REM = WIDTH - k * GROUP;   // operand bits still to be added
        localparam int SW  = (k + 1) * GROUP;     // sum bits known after this slice

        logic [REM-1:0] a_cur;
        logic [REM-1:0] b_cur;
        logic           c_cur;
        logic           v_cur;
        logic [GROUP:0] r;
        logic [SW-1:0]  s_out;

        if (k == 0) begin : g_in
            assign a_cur = a;
            assign b_cur = b_eff;
            assign c_cur = c0;
            assign v_cur = in_valid;
            assign s_out = r[GROUP-1:0];
        end else begin : g_reg
            logic [REM-1:0]      a_q;
            logic [REM-1:0]      b_q;
            logic [SW-GROUP-1:0] s_q;
            logic                c_q;
            logic                v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (en) begin
                    a_q <= g_stage[k-1].a_cur[REM+GROUP-1:GROUP];
                    b_q <= g_stage[k-1].b_cur[REM+GROUP-1:GROUP];
                    s_q <= g_stage[k-1].s_out;
                    c_q <= g_stage[k-1].r[GROUP];
                    v_q <= g_stage[k-1].v_cur;
                end
            end

            assign a_cur = a_q;
            assign b_cur = b_q;
            assign c_cur = c_q;
            assign v_cur = v_q;
            assign s_out = {r[GROUP-1:0], s_q};
        end

        assign r = cla_slice(a_cur[GROUP-1:0], b_cur[GROUP-1:0], c_cur);
    end

    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b' ^ c_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (en) begin
            out_valid <= g_stage[LAT-1].v_cur;
            sum       <= g_stage[LAT-1].s_out;
            cout      <= g_stage[LAT-1].r[GROUP];
            ovf       <= g_stage[LAT-1].r[GROUP]
                       ^ (g_stage[LAT-1].r[GROUP-1]
                          ^ g_stage[LAT-1].a_cur[GROUP-1]
                          ^ g_stage[LAT-1].b_cur[GROUP-1]);
            zero      <= ~|g_stage[LAT-1].s_out;
        end
    end

endmodule
